// File: rtl/hpio_tx_bringup_ctrl.sv
// hpio_tx_bringup_ctrl: bring-up sequencer and data gate for the HPIO transmit path.
// Steps PLL lock -> reset seq -> delay ready -> VTC -> training -> run, with timeouts and lock-loss recovery.
module hpio_tx_bringup_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned TRAIN_CYCLES   = 256,
  parameter logic [7:0]  TRAIN_PATTERN  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       retry,
  input  logic       pll_locked,
  input  logic       rst_seq_done,
  input  logic       dly_rdy,
  input  logic       vtc_rdy,
  input  logic [7:0] data_in,
  output logic       en_vtc,
  output logic [7:0] data_out,
  output logic       link_up,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] lock_loss_cnt,
  output logic [3:0] state_dbg
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TRAIN_W = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WAIT_PLL = 4'd1,
    S_WAIT_RST = 4'd2,
    S_WAIT_DLY = 4'd3,
    S_WAIT_VTC = 4'd4,
    S_TRAIN    = 4'd5,
    S_RUN      = 4'd6,
    S_ERROR    = 4'd7
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  state_t               w_advState;
  logic [TIMER_W-1:0]   r_timer;
  logic [TRAIN_W-1:0]   r_trainCnt;
  logic [2:0]           r_errCode;
  logic [2:0]           w_nextErrCode;
  logic [2:0]           w_waitCode;
  logic [7:0]           r_lockLossCnt;
  logic [3:0]           r_statusMeta;
  logic [3:0]           r_statusSync;
  logic                 r_enVtc;
  logic                 r_linkUp;
  logic                 r_err;
  logic [7:0]           r_dataOut;
  logic                 w_waitCond;
  logic                 w_lockLoss;
  logic                 w_pllS;
  logic                 w_rstS;
  logic                 w_dlyS;
  logic                 w_vtcS;

  // Status bits are asynchronous to clk; two flops before anything decides on them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_statusMeta <= '0;
      r_statusSync <= '0;
    end else begin
      r_statusMeta <= {vtc_rdy, dly_rdy, rst_seq_done, pll_locked};
      r_statusSync <= r_statusMeta;
    end
  end

  assign w_pllS = r_statusSync[0];
  assign w_rstS = r_statusSync[1];
  assign w_dlyS = r_statusSync[2];
  assign w_vtcS = r_statusSync[3];

  always_comb begin
    w_nextState   = r_state;
    w_nextErrCode = r_errCode;
    w_advState    = r_state;
    w_waitCond    = 1'b0;
    w_waitCode    = 3'd0;
    w_lockLoss    = 1'b0;
    case (r_state)
      S_WAIT_PLL: begin w_waitCond = w_pllS; w_waitCode = 3'd1; w_advState = S_WAIT_RST; end
      S_WAIT_RST: begin w_waitCond = w_rstS; w_waitCode = 3'd2; w_advState = S_WAIT_DLY; end
      S_WAIT_DLY: begin w_waitCond = w_dlyS; w_waitCode = 3'd3; w_advState = S_WAIT_VTC; end
      S_WAIT_VTC: begin w_waitCond = w_vtcS; w_waitCode = 3'd4; w_advState = S_TRAIN;    end
      default: ;
    endcase
    // Disable beats lock loss, lock loss beats progress; a ready status on the timeout cycle still advances.
    if (!enable && r_state != S_ERROR) begin
      w_nextState = S_IDLE;
    end else if (!w_pllS && (r_state inside {S_WAIT_RST, S_WAIT_DLY, S_WAIT_VTC, S_TRAIN, S_RUN})) begin
      w_nextState = S_WAIT_PLL;
      w_lockLoss  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: w_nextState = S_WAIT_PLL;
        S_WAIT_PLL, S_WAIT_RST, S_WAIT_DLY, S_WAIT_VTC: begin
          if (w_waitCond) begin
            w_nextState = w_advState;
          end else if (r_timer == TIMER_LAST) begin
            w_nextState   = S_ERROR;
            w_nextErrCode = w_waitCode;
          end
        end
        S_TRAIN: if (r_trainCnt == TRAIN_LAST) w_nextState = S_RUN;
        S_ERROR: begin
          if (retry) begin
            w_nextState   = S_WAIT_PLL;
            w_nextErrCode = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_errCode     <= 3'd0;
      r_timer       <= '0;
      r_trainCnt    <= '0;
      r_lockLossCnt <= 8'd0;
      r_enVtc       <= 1'b0;
      r_linkUp      <= 1'b0;
      r_err         <= 1'b0;
      r_dataOut     <= 8'h00;
    end else begin
      r_state   <= w_nextState;
      r_errCode <= w_nextErrCode;
      if (w_nextState != r_state) r_timer <= '0;
      else if (w_waitCode != 3'd0) r_timer <= r_timer + TIMER_W'(1);
      if (r_state != S_TRAIN) r_trainCnt <= '0;
      else r_trainCnt <= r_trainCnt + TRAIN_W'(1);
      if (w_lockLoss && r_lockLossCnt != 8'hFF) r_lockLossCnt <= r_lockLossCnt + 8'd1;
      // Output decodes follow the current state, so they trail state_dbg by one cycle.
      r_enVtc  <= (r_state inside {S_WAIT_VTC, S_TRAIN, S_RUN});
      r_linkUp <= (r_state == S_RUN);
      r_err    <= (r_state == S_ERROR);
      case (r_state)
        S_RUN:   r_dataOut <= data_in;
        S_TRAIN: r_dataOut <= TRAIN_PATTERN;
        default: r_dataOut <= 8'h00;
      endcase
    end
  end

  assign en_vtc        = r_enVtc;
  assign data_out      = r_dataOut;
  assign link_up       = r_linkUp;
  assign err           = r_err;
  assign err_code      = r_errCode;
  assign lock_loss_cnt = r_lockLossCnt;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_hpio_tx_bringup_ctrl.sv
// tb_hpio_tx_bringup_ctrl: directed scenarios for the HPIO TX bring-up sequencer.
// Samples 1 ns after each rising edge; data_in is a free-running counter that steps on falling edges.
module tb_hpio_tx_bringup_ctrl;

  localparam logic [7:0] PAT = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       retry = 1'b0;
  logic       pllLocked = 1'b0;
  logic       rstSeqDone = 1'b0;
  logic       dlyRdy = 1'b0;
  logic       vtcRdy = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       enVtc;
  logic [7:0] dataOut;
  logic       linkUp;
  logic       errOut;
  logic [2:0] errCode;
  logic [7:0] lockLossCnt;
  logic [3:0] stateDbg;

  int vectors = 0;
  int miscompares = 0;

  hpio_tx_bringup_ctrl #(
    .TIMEOUT_CYCLES(64),
    .TRAIN_CYCLES  (16),
    .TRAIN_PATTERN (PAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .retry        (retry),
    .pll_locked   (pllLocked),
    .rst_seq_done (rstSeqDone),
    .dly_rdy      (dlyRdy),
    .vtc_rdy      (vtcRdy),
    .data_in      (dataIn),
    .en_vtc       (enVtc),
    .data_out     (dataOut),
    .link_up      (linkUp),
    .err          (errOut),
    .err_code     (errCode),
    .lock_loss_cnt(lockLossCnt),
    .state_dbg    (stateDbg)
  );

  always #5 clk = ~clk;
  always @(negedge clk) dataIn = dataIn + 8'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vectors += 7;
    if (stateDbg !== 4'd0)    begin $display("[TB] FAIL reset_state got=%0d exp=0", stateDbg); miscompares++; end
    if (enVtc !== 1'b0)       begin $display("[TB] FAIL reset_en_vtc got=%b exp=0", enVtc); miscompares++; end
    if (dataOut !== 8'h00)    begin $display("[TB] FAIL reset_data_out got=%h exp=00", dataOut); miscompares++; end
    if (linkUp !== 1'b0)      begin $display("[TB] FAIL reset_link_up got=%b exp=0", linkUp); miscompares++; end
    if (errOut !== 1'b0)      begin $display("[TB] FAIL reset_err got=%b exp=0", errOut); miscompares++; end
    if (errCode !== 3'd0)     begin $display("[TB] FAIL reset_err_code got=%0d exp=0", errCode); miscompares++; end
    if (lockLossCnt !== 8'd0) begin $display("[TB] FAIL reset_lock_loss_cnt got=%0d exp=0", lockLossCnt); miscompares++; end
    reset = 1'b0;
    tick();
    vectors++;
    if (stateDbg !== 4'd0) begin $display("[TB] FAIL idle_disabled got=%0d exp=0", stateDbg); miscompares++; end
  endtask

  task automatic test_nominal();
    logic [3:0] expState;
    logic [7:0] expData;
    pllLocked = 1'b1; rstSeqDone = 1'b1; dlyRdy = 1'b1; vtcRdy = 1'b1;
    repeat (3) tick();
    enable = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      expState = (i <= 4) ? 4'(i) : (i <= 20) ? 4'd5 : 4'd6;
      expData  = (i <= 5) ? 8'h00 : (i <= 21) ? PAT : dataIn;
      vectors += 4;
      if (stateDbg !== expState) begin $display("[TB] FAIL nominal_state cyc=%0d got=%0d exp=%0d", i, stateDbg, expState); miscompares++; end
      if (dataOut !== expData)   begin $display("[TB] FAIL nominal_data cyc=%0d got=%h exp=%h", i, dataOut, expData); miscompares++; end
      if (enVtc !== (i >= 5))    begin $display("[TB] FAIL nominal_en_vtc cyc=%0d got=%b exp=%b", i, enVtc, (i >= 5)); miscompares++; end
      if (linkUp !== (i >= 22))  begin $display("[TB] FAIL nominal_link_up cyc=%0d got=%b exp=%b", i, linkUp, (i >= 22)); miscompares++; end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] expState;
    int cycles;
    enable = 1'b0;
    dlyRdy = 1'b0;
    tick();
    vectors++;
    if (stateDbg !== 4'd0) begin $display("[TB] FAIL disable_from_run got=%0d exp=0", stateDbg); miscompares++; end
    repeat (3) tick();
    enable = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      expState = (i <= 3) ? 4'(i) : (i <= 66) ? 4'd3 : 4'd7;
      vectors += 5;
      if (stateDbg !== expState)                   begin $display("[TB] FAIL timeout_state cyc=%0d got=%0d exp=%0d", i, stateDbg, expState); miscompares++; end
      if (errOut !== (i >= 68))                    begin $display("[TB] FAIL timeout_err cyc=%0d got=%b exp=%b", i, errOut, (i >= 68)); miscompares++; end
      if (errCode !== ((i >= 67) ? 3'd3 : 3'd0))   begin $display("[TB] FAIL timeout_err_code cyc=%0d got=%0d", i, errCode); miscompares++; end
      if (enVtc !== 1'b0)                          begin $display("[TB] FAIL timeout_en_vtc cyc=%0d got=%b exp=0", i, enVtc); miscompares++; end
      if (dataOut !== 8'h00)                       begin $display("[TB] FAIL timeout_data cyc=%0d got=%h exp=00", i, dataOut); miscompares++; end
    end
    // ERROR ignores enable.
    enable = 1'b0;
    repeat (4) tick();
    vectors += 3;
    if (stateDbg !== 4'd7) begin $display("[TB] FAIL error_hold_state got=%0d exp=7", stateDbg); miscompares++; end
    if (errOut !== 1'b1)   begin $display("[TB] FAIL error_hold_err got=%b exp=1", errOut); miscompares++; end
    if (errCode !== 3'd3)  begin $display("[TB] FAIL error_hold_code got=%0d exp=3", errCode); miscompares++; end
    dlyRdy = 1'b1;
    repeat (3) tick();
    enable = 1'b1;
    retry = 1'b1;
    tick();
    retry = 1'b0;
    vectors += 3;
    if (stateDbg !== 4'd1) begin $display("[TB] FAIL retry_state got=%0d exp=1", stateDbg); miscompares++; end
    if (errCode !== 3'd0)  begin $display("[TB] FAIL retry_err_code got=%0d exp=0", errCode); miscompares++; end
    if (errOut !== 1'b1)   begin $display("[TB] FAIL retry_err_lag got=%b exp=1", errOut); miscompares++; end
    tick();
    vectors += 2;
    if (errOut !== 1'b0)   begin $display("[TB] FAIL retry_err_clear got=%b exp=0", errOut); miscompares++; end
    if (stateDbg !== 4'd2) begin $display("[TB] FAIL retry_walk got=%0d exp=2", stateDbg); miscompares++; end
    cycles = 2;
    while (stateDbg !== 4'd6 && cycles < 60) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != 21) begin $display("[TB] FAIL retry_to_run cycles got=%0d exp=21", cycles); miscompares++; end
  endtask

  task automatic test_lock_loss();
    logic [3:0] expState;
    logic [7:0] expData;
    repeat (2) tick();
    pllLocked = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 5) pllLocked = 1'b1;
      expState = (i <= 2) ? 4'd6 : (i <= 7) ? 4'd1 : (i == 8) ? 4'd2 : (i == 9) ? 4'd3 :
                 (i == 10) ? 4'd4 : (i <= 26) ? 4'd5 : 4'd6;
      expData  = (i <= 3) ? dataIn : (i <= 11) ? 8'h00 : (i <= 27) ? PAT : dataIn;
      vectors += 4;
      if (stateDbg !== expState) begin $display("[TB] FAIL lockloss_state cyc=%0d got=%0d exp=%0d", i, stateDbg, expState); miscompares++; end
      if (dataOut !== expData)   begin $display("[TB] FAIL lockloss_data cyc=%0d got=%h exp=%h", i, dataOut, expData); miscompares++; end
      if (linkUp !== (i <= 3 || i >= 28)) begin $display("[TB] FAIL lockloss_link_up cyc=%0d got=%b", i, linkUp); miscompares++; end
      if (lockLossCnt !== ((i >= 3) ? 8'd1 : 8'd0)) begin $display("[TB] FAIL lockloss_cnt cyc=%0d got=%0d", i, lockLossCnt); miscompares++; end
    end
  endtask

  task automatic test_race();
    logic [3:0] expState;
    enable = 1'b0;
    vtcRdy = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      expState = (i <= 3) ? 4'(i) : (i <= 67) ? 4'd4 : 4'd5;
      vectors += 3;
      if (stateDbg !== expState) begin $display("[TB] FAIL race_state cyc=%0d got=%0d exp=%0d", i, stateDbg, expState); miscompares++; end
      if (errOut !== 1'b0)       begin $display("[TB] FAIL race_err cyc=%0d got=%b exp=0", i, errOut); miscompares++; end
      if (errCode !== 3'd0)      begin $display("[TB] FAIL race_err_code cyc=%0d got=%0d exp=0", i, errCode); miscompares++; end
      if (i == 4 || i == 5) begin
        vectors++;
        if (enVtc !== (i == 5)) begin $display("[TB] FAIL race_en_vtc_rise cyc=%0d got=%b exp=%b", i, enVtc, (i == 5)); miscompares++; end
      end
      if (i == 65) vtcRdy = 1'b1;
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    tick();
    vectors++;
    if (stateDbg !== 4'd0) begin $display("[TB] FAIL train_disable_state got=%0d exp=0", stateDbg); miscompares++; end
    tick();
    vectors += 2;
    if (enVtc !== 1'b0)    begin $display("[TB] FAIL train_disable_en_vtc got=%b exp=0", enVtc); miscompares++; end
    if (dataOut !== 8'h00) begin $display("[TB] FAIL train_disable_data got=%h exp=00", dataOut); miscompares++; end
  endtask

  task automatic test_saturation();
    int events;
    int cycles;
    logic [3:0] prevState;
    rstSeqDone = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    repeat (2) tick();
    vectors++;
    if (stateDbg !== 4'd2) begin $display("[TB] FAIL sat_setup_state got=%0d exp=2", stateDbg); miscompares++; end
    events = 0;
    cycles = 0;
    prevState = stateDbg;
    while (events < 300 && cycles < 2000) begin
      pllLocked = ~pllLocked;
      tick();
      cycles++;
      if (prevState == 4'd2 && stateDbg == 4'd1) begin
        events++;
        if (events == 100) begin
          vectors++;
          if (lockLossCnt !== 8'd101) begin $display("[TB] FAIL sat_midcount got=%0d exp=101", lockLossCnt); miscompares++; end
        end
      end
      prevState = stateDbg;
    end
    vectors += 2;
    if (events < 300)          begin $display("[TB] FAIL sat_events got=%0d exp=300", events); miscompares++; end
    if (lockLossCnt !== 8'd255) begin $display("[TB] FAIL sat_count got=%0d exp=255", lockLossCnt); miscompares++; end
    pllLocked = 1'b1;
    rstSeqDone = 1'b1;
    cycles = 0;
    while (stateDbg !== 4'd6 && cycles < 60) begin
      tick();
      cycles++;
    end
    tick();
    vectors += 3;
    if (stateDbg !== 4'd6)      begin $display("[TB] FAIL sat_reach_run got=%0d exp=6", stateDbg); miscompares++; end
    if (linkUp !== 1'b1)        begin $display("[TB] FAIL sat_link_up got=%b exp=1", linkUp); miscompares++; end
    if (lockLossCnt !== 8'd255) begin $display("[TB] FAIL sat_hold got=%0d exp=255", lockLossCnt); miscompares++; end
    reset = 1'b1;
    tick();
    vectors += 7;
    if (stateDbg !== 4'd0)    begin $display("[TB] FAIL midreset_state got=%0d exp=0", stateDbg); miscompares++; end
    if (lockLossCnt !== 8'd0) begin $display("[TB] FAIL midreset_cnt got=%0d exp=0", lockLossCnt); miscompares++; end
    if (linkUp !== 1'b0)      begin $display("[TB] FAIL midreset_link_up got=%b exp=0", linkUp); miscompares++; end
    if (enVtc !== 1'b0)       begin $display("[TB] FAIL midreset_en_vtc got=%b exp=0", enVtc); miscompares++; end
    if (dataOut !== 8'h00)    begin $display("[TB] FAIL midreset_data got=%h exp=00", dataOut); miscompares++; end
    if (errOut !== 1'b0)      begin $display("[TB] FAIL midreset_err got=%b exp=0", errOut); miscompares++; end
    if (errCode !== 3'd0)     begin $display("[TB] FAIL midreset_err_code got=%0d exp=0", errCode); miscompares++; end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_lock_loss();
    test_race();
    test_enable_drop();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
